// File: rtl/cordic_cos_iter.sv
// cordic_cos_iter: iterative rotation-mode CORDIC producing cos(angle).
// Input and outputs are signed Q2.30. The unit performs one micro-rotation per
// enabled clock and has a start/done handshake:
//   start is sampled only in IDLE or DONE while clk_en is high. When it is
//   accepted, angle is captured on that same edge. done is high for exactly
//   one enabled cycle, and cos_out becomes valid on the edge that raises done.
// Optional build macro: CORDIC_SIN_OUT_EN adds sin_out, which is the final y.
// dbg_state exposes the FSM encoding (0=IDLE, 1=RUN, 2=DONE).
module cordic_cos_iter #(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH-1:0] angle,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cos_out,
`ifdef CORDIC_SIN_OUT_EN
    output logic [WIDTH-1:0] sin_out,
`endif
    output logic [1:0]       dbg_state
);

    localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    // Gain-compensated start value 1/An = 0.6072529 in Q2.30.
    localparam logic [WIDTH-1:0] K_INIT = WIDTH'(32'h26DD3B6A);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    logic [IW-1:0]           iter_q, iter_d;
    logic [WIDTH-1:0]        cos_q, cos_d;
`ifdef CORDIC_SIN_OUT_EN
    logic [WIDTH-1:0]        sin_q, sin_d;
`endif

    logic signed [WIDTH-1:0] x_sh, y_sh, atan_v;
    logic signed [WIDTH-1:0] x_rot, y_rot, z_rot;
    logic                    rot_pos;
    logic                    last_iter;

    // atan(2^-i) in Q2.30, truncated.
    function automatic logic [31:0] atan_rom(input int i);
        logic [31:0] v;
        case (i)
            0:       v = 32'h3243F6A8;
            1:       v = 32'h1DAC6705;
            2:       v = 32'h0FADBAFC;
            3:       v = 32'h07F56EA6;
            4:       v = 32'h03FEAB76;
            5:       v = 32'h01FFD55B;
            6:       v = 32'h00FFFAAA;
            7:       v = 32'h007FFF55;
            8:       v = 32'h003FFFEA;
            9:       v = 32'h001FFFFD;
            10:      v = 32'h000FFFFF;
            11:      v = 32'h0007FFFF;
            12:      v = 32'h0003FFFF;
            13:      v = 32'h0001FFFF;
            14:      v = 32'h0000FFFF;
            15:      v = 32'h00007FFF;
            16:      v = 32'h00003FFF;
            17:      v = 32'h00001FFF;
            18:      v = 32'h00000FFF;
            19:      v = 32'h000007FF;
            20:      v = 32'h000003FF;
            21:      v = 32'h000001FF;
            default: v = 32'h00000000;
        endcase
        return v;
    endfunction

    // One micro-rotation: steer toward z=0 using arithmetic shifts with no rounding.
    always_comb begin
        x_sh      = x_q >>> iter_q;
        y_sh      = y_q >>> iter_q;
        atan_v    = WIDTH'(atan_rom(int'(iter_q)));
        rot_pos   = ~z_q[WIDTH-1];
        x_rot     = rot_pos ? (x_q - y_sh) : (x_q + y_sh);
        y_rot     = rot_pos ? (y_q + x_sh) : (y_q - x_sh);
        z_rot     = rot_pos ? (z_q - atan_v) : (z_q + atan_v);
        last_iter = (iter_q == IW'(ITERATIONS - 1));
    end

    // Next-state logic: accept start in IDLE/DONE, iterate in RUN, publish the result on leaving RUN.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        iter_d  = iter_q;
        cos_d   = cos_q;
`ifdef CORDIC_SIN_OUT_EN
        sin_d   = sin_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    x_d     = K_INIT;
                    y_d     = '0;
                    z_d     = angle;
                    iter_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                x_d    = x_rot;
                y_d    = y_rot;
                z_d    = z_rot;
                iter_d = iter_q + 1'b1;
                if (last_iter) begin
                    state_d = S_DONE;
                    iter_d  = '0;
                    cos_d   = x_rot;
`ifdef CORDIC_SIN_OUT_EN
                    sin_d   = y_rot;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers: asynchronous clear, and all registers hold while clk_en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            cos_q   <= '0;
`ifdef CORDIC_SIN_OUT_EN
            sin_q   <= '0;
`endif
        end else if (clk_en) begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
            cos_q   <= cos_d;
`ifdef CORDIC_SIN_OUT_EN
            sin_q   <= sin_d;
`endif
        end
    end

    // Outputs are decoded directly from registered state.
    always_comb begin
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        cos_out   = cos_q;
`ifdef CORDIC_SIN_OUT_EN
        sin_out   = sin_q;
`endif
        dbg_state = state_q;
    end

endmodule
